// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong_renderer pixel/game pipeline:
// the game state enum, playfield geometry, VGA timing offsets, the serve
// position and the colour palette.
// No ports (package). The optional border (macro PONG_BORDER_EN) uses
// BORDER_W from here.
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        MISS  = 2'd2
    } game_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Visible playfield and the position of its first pixel in beam coordinates
    localparam coord_t SCREEN_W = 11'd640;
    localparam coord_t SCREEN_H = 11'd480;
    localparam coord_t X_OFFSET = 11'd145;
    localparam coord_t Y_OFFSET = 11'd36;

    localparam coord_t SERVE_X  = 11'd316;
    localparam coord_t SERVE_Y  = 11'd236;
    localparam coord_t BORDER_W = 11'd4;

    localparam rgb_t COLOR_BLACK = 24'h000000;
    localparam rgb_t COLOR_WHITE = 24'hFFFFFF;
    localparam rgb_t COLOR_RED   = 24'hFF0000;
    localparam rgb_t COLOR_GREEN = 24'h00FF00;
    localparam rgb_t COLOR_BG    = 24'h000040;

    // True when pos lies in the half-open span [start, start + len)
    function automatic logic inRange(input coord_t pos, input coord_t start, input coord_t len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/vs_edge_sync.sv
// -----------------------------------------------------------------------------
// vs_edge_sync
// Two-flop synchronizer for WIDTH asynchronous inputs, plus a registered
// rising-edge pulse on bit 0. Used for VGA_VS (edge output is the frame
// tick) and for the push buttons (edge output left unused).
// Ports:
//   CLOCK_50  in   system clock
//   reset     in   synchronous, active-high
//   async_i   in   [WIDTH] asynchronous inputs
//   sync_o    out  [WIDTH] synchronized levels
//   rise_o    out  one-cycle pulse on a rising edge of synchronized bit 0
// RESET_VAL sets the value the chain holds in reset; for an idle-high
// signal like VGA_VS this keeps an edge that lines up with reset release
// from producing a spurious pulse.
// -----------------------------------------------------------------------------
module vs_edge_sync #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic             prev_q;
    logic             rise_q;

    // Two-stage synchronizer followed by a one-cycle edge detector; the
    // pulse is registered so it arrives three cycles after the input rises.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            meta_q <= {WIDTH{RESET_VAL}};
            sync_q <= {WIDTH{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q[0];
            rise_q <= sync_q[0] & ~prev_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/pong_renderer.sv
// -----------------------------------------------------------------------------
// pong_renderer
// Pixel stage behind the VGA timing generator: maps beam coordinates to the
// 640x480 playfield, draws ball / paddle / background into a registered
// 24-bit colour, and runs a single-player ball-and-paddle game that
// advances once per frame.
// Ports:
//   CLOCK_50        in   50 MHz clock
//   reset           in   synchronous, active-high
//   x, y            in   [11] beam column / row
//   ativo_vga       in   active-video qualifier
//   VGA_VS          in   vertical sync (active low, asynchronous)
//   btn_left/right  in   paddle buttons (active high, asynchronous)
//   VGA_R/G/B       out  [8] registered colour, 1 cycle after x/y
//   frame_tick      out  one-cycle pulse at the end of each VS pulse
//   score           out  [8] consecutive paddle hits, saturating
// Build option: define PONG_BORDER_EN to draw a 4-pixel white border and
// move the left, right and top bounce limits in by the same amount.
// -----------------------------------------------------------------------------
module pong_renderer
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 64,
    parameter int PADDLE_H     = 8,
    parameter int PADDLE_Y     = 460,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_SPEED = 4,
    parameter int MISS_FRAMES  = 60
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        ativo_vga,
    input  logic        VGA_VS,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_tick,
    output logic [7:0]  score
);

    localparam coord_t BALL_SZ   = coord_t'(BALL_SIZE);
    localparam coord_t SPD       = coord_t'(BALL_SPEED);
    localparam coord_t PAD_W     = coord_t'(PADDLE_W);
    localparam coord_t PAD_H     = coord_t'(PADDLE_H);
    localparam coord_t PAD_Y     = coord_t'(PADDLE_Y);
    localparam coord_t PAD_SPD   = coord_t'(PADDLE_SPEED);
    localparam coord_t PAD_MAX   = SCREEN_W - PAD_W;
    localparam coord_t PAD_RESET = PAD_MAX >> 1;

`ifdef PONG_BORDER_EN
    localparam coord_t WALL = BORDER_W;
`else
    localparam coord_t WALL = 11'd0;
`endif

    localparam coord_t X_MIN  = WALL;
    localparam coord_t X_MAX  = SCREEN_W - BALL_SZ - WALL;
    localparam coord_t Y_MIN  = WALL;
    localparam coord_t MISS_Y = SCREEN_H - BALL_SZ;

    localparam int                MISS_W    = (MISS_FRAMES > 2) ? $clog2(MISS_FRAMES) : 1;
    localparam logic [MISS_W-1:0] MISS_INIT = MISS_W'(MISS_FRAMES - 1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

    // ---------------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------------
    logic [0:0] vsLevel_unused;
    logic [1:0] btnSync;
    logic       btnRise_unused;
    logic       btnLeft;
    logic       btnRight;

    vs_edge_sync #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) uVsSync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_i  (VGA_VS),
        .sync_o   (vsLevel_unused),
        .rise_o   (frame_tick)
    );

    vs_edge_sync #(
        .WIDTH     (2),
        .RESET_VAL (1'b0)
    ) uBtnSync (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .async_i  ({btn_right, btn_left}),
        .sync_o   (btnSync),
        .rise_o   (btnRise_unused)
    );

    assign btnLeft  = btnSync[0];
    assign btnRight = btnSync[1];

    // ---------------------------------------------------------------------
    // Game state
    // ---------------------------------------------------------------------
    game_state_t       state_q,    state_d;
    coord_t            ballX_q,    ballX_d;
    coord_t            ballY_q,    ballY_d;
    logic              dirRight_q, dirRight_d;
    logic              dirDown_q,  dirDown_d;
    coord_t            padX_q,     padX_d;
    logic [7:0]        score_q,    score_d;
    logic [MISS_W-1:0] missCnt_q,  missCnt_d;
    logic              paddleHit;

    // The ball is caught when, moving down, its bottom edge would reach the
    // paddle top within this frame's step and it overlaps the paddle span.
    assign paddleHit = dirDown_q
                    && (ballY_q + BALL_SZ + SPD >= PAD_Y)
                    && (ballY_q + BALL_SZ <= PAD_Y)
                    && (ballX_q + BALL_SZ > padX_q)
                    && (ballX_q < padX_q + PAD_W);

    // Next-state logic. Everything holds outside the frame_tick cycle, so
    // updates happen during vertical blanking. The two ball axes are
    // resolved independently, which lets a wall bounce and a paddle catch
    // land on the same frame.
    always_comb begin
        state_d    = state_q;
        ballX_d    = ballX_q;
        ballY_d    = ballY_q;
        dirRight_d = dirRight_q;
        dirDown_d  = dirDown_q;
        padX_d     = padX_q;
        score_d    = score_q;
        missCnt_d  = missCnt_q;

        if (frame_tick) begin
            if (btnLeft && !btnRight) begin
                padX_d = (padX_q <= PAD_SPD) ? 11'd0 : padX_q - PAD_SPD;
            end else if (btnRight && !btnLeft) begin
                padX_d = (padX_q >= PAD_MAX - PAD_SPD) ? PAD_MAX : padX_q + PAD_SPD;
            end

            unique case (state_q)
                SERVE: begin
                    ballX_d    = SERVE_X;
                    ballY_d    = SERVE_Y;
                    dirRight_d = 1'b1;
                    dirDown_d  = 1'b0;
                    if (btnLeft || btnRight) begin
                        state_d = PLAY;
                    end
                end

                PLAY: begin
                    if (dirRight_q) begin
                        if (ballX_q >= X_MAX - SPD) begin
                            ballX_d    = X_MAX;
                            dirRight_d = 1'b0;
                        end else begin
                            ballX_d = ballX_q + SPD;
                        end
                    end else begin
                        if (ballX_q <= X_MIN + SPD) begin
                            ballX_d    = X_MIN;
                            dirRight_d = 1'b1;
                        end else begin
                            ballX_d = ballX_q - SPD;
                        end
                    end

                    if (!dirDown_q) begin
                        if (ballY_q <= Y_MIN + SPD) begin
                            ballY_d   = Y_MIN;
                            dirDown_d = 1'b1;
                        end else begin
                            ballY_d = ballY_q - SPD;
                        end
                    end else if (paddleHit) begin
                        ballY_d   = PAD_Y - BALL_SZ;
                        dirDown_d = 1'b0;
                        score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    end else begin
                        ballY_d = ballY_q + SPD;
                        if (ballY_q + SPD >= MISS_Y) begin
                            state_d   = MISS;
                            score_d   = 8'd0;
                            missCnt_d = MISS_INIT;
                        end
                    end
                end

                MISS: begin
                    if (missCnt_q == '0) begin
                        state_d    = SERVE;
                        ballX_d    = SERVE_X;
                        ballY_d    = SERVE_Y;
                        dirRight_d = 1'b1;
                        dirDown_d  = 1'b0;
                    end else begin
                        missCnt_d = missCnt_q - MISS_ONE;
                    end
                end

                default: state_d = SERVE;
            endcase
        end
    end

    // Game registers, returning to a fresh serve on reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= SERVE;
            ballX_q    <= SERVE_X;
            ballY_q    <= SERVE_Y;
            dirRight_q <= 1'b1;
            dirDown_q  <= 1'b0;
            padX_q     <= PAD_RESET;
            score_q    <= 8'd0;
            missCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            ballX_q    <= ballX_d;
            ballY_q    <= ballY_d;
            dirRight_q <= dirRight_d;
            dirDown_q  <= dirDown_d;
            padX_q     <= padX_d;
            score_q    <= score_d;
            missCnt_q  <= missCnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Pixel generation
    // ---------------------------------------------------------------------
    coord_t px;
    coord_t py;
    logic   visible;
    logic   onBall;
    logic   onPaddle;
    rgb_t   colour_d;
    rgb_t   rgb_q;
`ifdef PONG_BORDER_EN
    logic   onBorder;
`endif

    // Beam coordinates left of / above the playfield wrap to large values,
    // so a single unsigned compare rejects both sides.
    assign px       = x - X_OFFSET;
    assign py       = y - Y_OFFSET;
    assign visible  = ativo_vga && (px < SCREEN_W) && (py < SCREEN_H);
    assign onBall   = inRange(px, ballX_q, BALL_SZ) && inRange(py, ballY_q, BALL_SZ);
    assign onPaddle = inRange(px, padX_q, PAD_W) && inRange(py, PAD_Y, PAD_H);
`ifdef PONG_BORDER_EN
    assign onBorder = (px < BORDER_W) || (px >= SCREEN_W - BORDER_W)
                   || (py < BORDER_W) || (py >= SCREEN_H - BORDER_W);
`endif

    // Layer priority: ball over paddle over border over background. The
    // ball turns red while a miss is being shown.
    always_comb begin
        colour_d = COLOR_BLACK;
        if (visible) begin
            if (onBall) begin
                colour_d = (state_q == MISS) ? COLOR_RED : COLOR_WHITE;
            end else if (onPaddle) begin
                colour_d = COLOR_GREEN;
`ifdef PONG_BORDER_EN
            end else if (onBorder) begin
                colour_d = COLOR_WHITE;
`endif
            end else begin
                colour_d = COLOR_BG;
            end
        end
    end

    // One-cycle colour register; x holds for two cycles so every 25 MHz
    // pixel sees a full stable period at the DAC.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rgb_q <= COLOR_BLACK;
        end else begin
            rgb_q <= colour_d;
        end
    end

    assign VGA_R = rgb_q.r;
    assign VGA_G = rgb_q.g;
    assign VGA_B = rgb_q.b;
    assign score = score_q;

endmodule

// File: tb/tb_pong_renderer.sv
// -----------------------------------------------------------------------------
// tb_pong_renderer
// Scoreboard bench for pong_renderer. applyStimulus drives one pixel
// probe and queues the hand-derived colour and score; a monitor pops the
// queue one cycle later, when the registered colour is presented, and
// compares. Frames are produced by pulsing VGA_VS, and each frame checks
// the frame_tick latency and width directly.
// -----------------------------------------------------------------------------
module tb_pong_renderer;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [10:0] x;
    logic [10:0] y;
    logic        ativo_vga;
    logic        VGA_VS;
    logic        btn_left;
    logic        btn_right;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        frame_tick;
    logic [7:0]  score;

    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;
    localparam logic [23:0] BG    = 24'h000040;
`ifdef PONG_BORDER_EN
    localparam logic [23:0] EDGE_RGB = WHITE;
`else
    localparam logic [23:0] EDGE_RGB = BG;
`endif

    typedef struct {
        string       name;
        logic [23:0] rgb;
        logic [7:0]  score;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    logic issue     = 1'b0;
    logic respValid = 1'b0;

    pong_renderer dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .ativo_vga  (ativo_vga),
        .VGA_VS     (VGA_VS),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .frame_tick (frame_tick),
        .score      (score)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // The colour for a probe is registered on the edge after it is driven
    always @(posedge CLOCK_50) respValid <= issue;

    task automatic checkOutput();
        exp_t        e;
        logic [23:0] got;
        got = {VGA_R, VGA_G, VGA_B};
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_underflow: got rgb=%06h, required a queued expectation", got);
            return;
        end
        e = expQ.pop_front();
        if (got !== e.rgb) begin
            failures++;
            $display("[TB] FAIL %s rgb: got %06h, expected %06h", e.name, got, e.rgb);
        end
        checks++;
        if (score !== e.score) begin
            failures++;
            $display("[TB] FAIL %s score: got %0d, expected %0d", e.name, score, e.score);
        end
    endtask

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (respValid) checkOutput();
        end
    end

    // Drive one probe at playfield (px, py); called on a falling edge
    task automatic applyStimulus(input string name, input int pxv, input int pyv,
                                 input logic act, input logic [23:0] expRgb,
                                 input logic [7:0] expScore);
        exp_t e;
        x         = 11'(pxv + 145);
        y         = 11'(pyv + 36);
        ativo_vga = act;
        e.name    = name;
        e.rgb     = expRgb;
        e.score   = expScore;
        expQ.push_back(e);
        issue = 1'b1;
        @(negedge CLOCK_50);
        issue     = 1'b0;
        ativo_vga = 1'b0;
    endtask

    // One VS pulse with the given buttons held; frame_tick must show up on
    // the third sampling edge after VS rises and last exactly one cycle.
    task automatic doFrame(input logic l, input logic r);
        int lat;
        lat       = 0;
        btn_left  = l;
        btn_right = r;
        repeat (3) @(negedge CLOCK_50);
        VGA_VS = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        VGA_VS = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLOCK_50);
            if (frame_tick) begin
                lat = i;
                break;
            end
        end
        @(negedge CLOCK_50);
        checks++;
        if (lat != 3 || frame_tick !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frame_tick: latency %0d width_ok=%0b, expected latency 3 width_ok=1",
                     lat, !frame_tick);
        end
    endtask

    initial begin
        #1200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        reset     = 1'b1;
        x         = '0;
        y         = '0;
        ativo_vga = 1'b0;
        VGA_VS    = 1'b1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        repeat (3) @(negedge CLOCK_50);

        $display("[TB] reset and static drawing");
        applyStimulus("reset_black", 316, 236, 1'b1, BLACK, 8'd0);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        applyStimulus("serve_ball",      316, 236, 1'b1, WHITE,    8'd0);
        applyStimulus("serve_ball_edge", 323, 243, 1'b1, WHITE,    8'd0);
        applyStimulus("right_of_ball",   324, 236, 1'b1, BG,       8'd0);
        applyStimulus("paddle_left",     288, 460, 1'b1, GREEN,    8'd0);
        applyStimulus("left_of_paddle",  287, 460, 1'b1, BG,       8'd0);
        applyStimulus("paddle_corner",   351, 467, 1'b1, GREEN,    8'd0);
        applyStimulus("right_of_paddle", 352, 460, 1'b1, BG,       8'd0);
        applyStimulus("blank_inactive",  316, 236, 1'b0, BLACK,    8'd0);
        applyStimulus("blank_px645",     645, 236, 1'b1, BLACK,    8'd0);
        applyStimulus("blank_py480",     100, 480, 1'b1, BLACK,    8'd0);
        applyStimulus("edge_left",         0, 100, 1'b1, EDGE_RGB, 8'd0);
        applyStimulus("edge_right",      639, 100, 1'b1, EDGE_RGB, 8'd0);
        applyStimulus("edge_top",        100,   0, 1'b1, EDGE_RGB, 8'd0);
        applyStimulus("inside_left",       4, 100, 1'b1, BG,       8'd0);
        applyStimulus("inside_right",    635, 100, 1'b1, BG,       8'd0);

`ifndef PONG_BORDER_EN
        $display("[TB] paddle clamp left, ball in flight");
        for (int i = 0; i < 80; i++) doFrame(1'b1, 1'b0);
        applyStimulus("pad_at_zero",     0, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("pad_zero_end",   63, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("pad_zero_past",  64, 460, 1'b1, BG,    8'd0);
        applyStimulus("ball_n79",      474,  78, 1'b1, WHITE, 8'd0);
        applyStimulus("ball_n79_left", 473,  78, 1'b1, BG,    8'd0);
        applyStimulus("ball_n79_right",482,  78, 1'b1, BG,    8'd0);

        $display("[TB] both buttons hold the paddle");
        for (int i = 0; i < 5; i++) doFrame(1'b1, 1'b1);
        applyStimulus("pad_both_hold",   0, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("pad_both_past",  64, 460, 1'b1, BG,    8'd0);
        applyStimulus("ball_n84",      484,  68, 1'b1, WHITE, 8'd0);

        $display("[TB] paddle moves right under the ball path");
        for (int i = 0; i < 60; i++) doFrame(1'b0, 1'b1);
        applyStimulus("pad_240",       240, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("pad_240_left",  239, 460, 1'b1, BG,    8'd0);
        applyStimulus("pad_240_end",   303, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("pad_240_past",  304, 460, 1'b1, BG,    8'd0);
        applyStimulus("ball_n144",     604,  52, 1'b1, WHITE, 8'd0);

        $display("[TB] paddle hit");
        for (int i = 0; i < 200; i++) doFrame(1'b0, 1'b0);
        applyStimulus("hit_ball",      260, 452, 1'b1, WHITE, 8'd1);
        applyStimulus("hit_ball_left", 259, 452, 1'b1, BG,    8'd1);
        doFrame(1'b0, 1'b0);
        applyStimulus("after_hit_up",  258, 450, 1'b1, WHITE, 8'd1);
        applyStimulus("after_hit_gap", 258, 458, 1'b1, BG,    8'd1);

        $display("[TB] miss");
        for (int i = 0; i < 60; i++) doFrame(1'b0, 1'b1);
        applyStimulus("pad_480",       480, 460, 1'b1, GREEN, 8'd1);
        applyStimulus("pad_480_left",  479, 460, 1'b1, BG,    8'd1);
        for (int i = 0; i < 400; i++) doFrame(1'b0, 1'b0);
        applyStimulus("ball_pre_miss", 602, 470, 1'b1, WHITE, 8'd1);
        doFrame(1'b0, 1'b0);
        applyStimulus("miss_red",      600, 472, 1'b1, RED,   8'd0);
        applyStimulus("miss_left",     599, 472, 1'b1, BG,    8'd0);
        for (int i = 0; i < 59; i++) doFrame(1'b0, 1'b0);
        applyStimulus("miss_tick59",   600, 472, 1'b1, RED,   8'd0);
        doFrame(1'b0, 1'b0);
        applyStimulus("serve_again",   316, 236, 1'b1, WHITE, 8'd0);
        applyStimulus("miss_cleared",  600, 472, 1'b1, BG,    8'd0);
`else
        $display("[TB] border top-wall bounce");
        doFrame(1'b1, 1'b0);
        for (int i = 0; i < 116; i++) doFrame(1'b0, 1'b0);
        applyStimulus("ball_at_wall",  548, 4, 1'b1, WHITE, 8'd0);
        applyStimulus("border_above",  548, 3, 1'b1, WHITE, 8'd0);
        doFrame(1'b0, 1'b0);
        applyStimulus("ball_bounced",  550, 6, 1'b1, WHITE, 8'd0);
        applyStimulus("above_bounced", 550, 5, 1'b1, BG,    8'd0);
`endif

        $display("[TB] VS edge during reset");
        reset  = 1'b1;
        VGA_VS = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        VGA_VS = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            if (frame_tick) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL reset_vs_edge: got %0d ticks, expected 0", seen);
        end
        applyStimulus("reset_pad_home", 288, 460, 1'b1, GREEN, 8'd0);
        applyStimulus("reset_pad_old",  480, 460, 1'b1, BG,    8'd0);
        applyStimulus("reset_serve",    316, 236, 1'b1, WHITE, 8'd0);

        repeat (2) @(negedge CLOCK_50);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pong_renderer.md
# pong_renderer

Pixel-generation stage directly downstream of the VGA timing generator. It consumes the raw beam coordinates `x`/`y`, the `ativo_vga` qualifier and `VGA_VS`, and produces the 24-bit colour driven to the DAC. It also owns the game state for a single-player ball-and-paddle game: ball motion, wall bounce, paddle control, hit/miss detection and score. Positions update once per frame.

## Interface

Parameters:
- `BALL_SIZE`, 8: ball edge length in pixels.
- `PADDLE_W`, 64: paddle width in pixels.
- `PADDLE_H`, 8: paddle height in pixels.
- `PADDLE_Y`, 460: paddle top row.
- `BALL_SPEED`, 2: ball pixels per frame, per axis.
- `PADDLE_SPEED`, 4: paddle pixels per frame.
- `MISS_FRAMES`, 60: frames spent in MISS.

Ports (reset is `reset`, synchronous, active-high; clock is `CLOCK_50`):
- `CLOCK_50`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: synchronous, active-high.
- `x`, in, 11: beam column from the timing generator; changes every 2nd `CLOCK_50`.
- `y`, in, 11: beam row from the timing generator.
- `ativo_vga`, in, 1: active-video qualifier.
- `VGA_VS`, in, 1: vertical sync, active low.
- `btn_left`, in, 1: move paddle left, active-high, asynchronous.
- `btn_right`, in, 1: move paddle right, active-high, asynchronous.
- `VGA_R`, out, 8: red.
- `VGA_G`, out, 8: green.
- `VGA_B`, out, 8: blue.
- `frame_tick`, out, 1: one-cycle pulse per frame.
- `score`, out, 8: consecutive paddle hits.

## Operation

- **Playfield mapping:**
  - `px = x − 145` and `py = y − 36`, 11-bit unsigned.
  - The pixel is visible only when `ativo_vga` is high and `px < 640` and `py < 480`.
  - Every other pixel is black.
- **Input sync:** `VGA_VS`, `btn_left` and `btn_right` each pass through a 2-FF synchronizer.
- **Frame tick:** `frame_tick` fires on the rising edge of the synchronized `VGA_VS`, i.e. at the end of the sync pulse. All game state updates only in the `frame_tick` cycle.
- **Paddle position (`pad_x`, 0..576):**
  - Left only: subtract `PADDLE_SPEED`.
  - Right only: add `PADDLE_SPEED`.
  - Both or neither: hold.
  - Clamp to 0 and to 640 − `PADDLE_W`.
- **FSM states:** SERVE, PLAY, MISS.
  - **SERVE:** ball fixed at (316, 236), `dx` = right, `dy` = up. Any synchronized button high on a tick moves to PLAY.
  - **PLAY:** each axis moves `BALL_SPEED` in its direction.
    - Left wall: moving left with `bx` ≤ `BALL_SPEED` sets `bx` = 0 and flips `dx`. Right wall mirrors this at 640 − `BALL_SIZE`.
    - Top wall: `by` ≤ `BALL_SPEED` while moving up sets `by` = 0 and flips `dy`.
    - Paddle hit: requires moving down, `by + BALL_SIZE + BALL_SPEED` ≥ `PADDLE_Y`, `by + BALL_SIZE` ≤ `PADDLE_Y`, and horizontal overlap (`bx + BALL_SIZE > pad_x` and `bx < pad_x + PADDLE_W`). On a hit: `by` = `PADDLE_Y` − `BALL_SIZE`, `dy` = up, `score` +1, saturating at 255.
    - Miss: without a hit, reaching `by` ≥ 480 − `BALL_SIZE` moves to MISS, clears `score` to 0 and loads `miss_cnt` = `MISS_FRAMES` − 1.
    - Wall and paddle events on the same tick are evaluated per axis independently.
  - **MISS:** ball frozen. `miss_cnt` decrements per tick; at 0 the next tick enters SERVE.
- **Colour priority:** ball > paddle > border (see Configuration) > background.
  - Ball: white `FF/FF/FF`; red `FF/00/00` while in MISS.
  - Paddle: `00/FF/00`.
  - Background: `00/00/40`.

## Timing

- **Reset values:**
  - Outputs: RGB = 0, `frame_tick` = 0, `score` = 0.
  - Internal: state = SERVE, ball at (316, 236), `pad_x` = 288, `miss_cnt` = 0.
- **Colour latency:** colour outputs are registered with 1 `CLOCK_50` latency from `x`/`y`. Because `x` is stable for 2 cycles, each pixel is valid for at least one full 25 MHz period.
- **Tick latency:** `frame_tick` rises 3 cycles after `VGA_VS` rises: 2 synchronizer cycles plus 1 edge register.
- **Update visibility:** a state update in a tick cycle is visible in RGB from the next cycle. The update happens in blanking, so there is no tearing.
- **Reset mid-frame:** RGB outputs black on the next cycle and the game returns to SERVE. A `VGA_VS` edge coinciding with reset is ignored.

## Configuration

- **`PONG_BORDER_EN` defined:** a 4-pixel white border is drawn at `px` < 4, `px` ≥ 636, `py` < 4 and `py` ≥ 476. The wall bounce limits shrink by 4 pixels on left, right and top.
- **`PONG_BORDER_EN` undefined:** no border logic; walls are at the playfield edge.

## Structure

- **`pong_pkg`:** holds the state enum (SERVE, PLAY, MISS), the screen constants (640, 480, offsets 145/36), the colour constants, and the serve position.
- **`vs_edge_sync` sub-module:** a 2-FF synchronizer plus rising-edge detector producing `frame_tick`. It is reused for the button synchronizers, without the edge output.

## Test plan

- **Reset:** assert reset, then release. RGB = 0, `score` = 0; drawing the pixel at `px` = 316, `py` = 236 gives white.
- **Paddle clamp:** hold `btn_left` for 80 frames. `pad_x` reaches 0 and stays 0. Then hold both buttons: `pad_x` unchanged.
- **Paddle hit:** serve, then hold `pad_x` under the falling ball. `dy` flips up, `by` = 452, `score` = 1, and no MISS.
- **Miss:** move the paddle away. State goes to MISS, the ball pixel reads `FF/00/00`, and `score` = 0. SERVE follows exactly 60 ticks later.
- **Blanking:** with `ativo_vga` = 0, or with `px` = 645 while `ativo_vga` = 1, RGB = 0 on the next cycle.
- **Border:** with `PONG_BORDER_EN`, pixel (0, 100) is white and the ball bounces at `bx` = 4. Without the macro, pixel (0, 100) is `00/00/40`.
